// File: rtl/pipe_stall_ctrl_pkg.sv
// rtl/pipe_stall_ctrl_pkg.sv - shared stall bus encodings, stage indices and FSM states for pipe_stall_ctrl
package pipe_stall_ctrl_pkg;

  localparam int STALL_BUS_W = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  localparam logic [STALL_BUS_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_BUS_W-1:0] STALL_LOAD = 6'b000111;
  localparam logic [STALL_BUS_W-1:0] STALL_EX   = 6'b001111;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LD_BUBBLE = 2'd1,
    EX_WAIT   = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// rtl/pipe_stall_ctrl_hazard_detect.sv - combinational load-use compare between a load destination and ID sources
module pipe_stall_ctrl_hazard_detect (
  input  logic       ex_is_load,
  input  logic [4:0] ex_waddr,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  output logic       load_use
);

  logic rs_hit;
  logic rt_hit;

  // $zero is never a real dependency, so a load into r0 never stalls
  assign rs_hit   = id_use_rs & (id_rs == ex_waddr);
  assign rt_hit   = id_use_rt & (id_rt == ex_waddr);
  assign load_use = ex_is_load & (ex_waddr != 5'd0) & (rs_hit | rt_hit);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall sequencer (load-use bubble, multi-cycle EX wait, watchdog); optional STALL_PERF_EN perf counters
import pipe_stall_ctrl_pkg::*;

module pipe_stall_ctrl #(
  parameter int STALL_W     = 6,
  parameter int EX_WAIT_MAX = 64,
  parameter int CNT_W       = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_is_load,
  input  logic [4:0]         ex_waddr,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic               id_use_rs,
  input  logic               id_use_rt,
  input  logic               ex_mc_req,
  input  logic               ex_mc_done,
  output logic [STALL_W-1:0] stall,
  output logic               id_buf_cap,
`ifdef STALL_PERF_EN
  output logic [31:0]        perf_stall_cycles,
  output logic [31:0]        perf_load_events,
`endif
  output logic               ex_timeout
);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   timeout_q, timeout_d;
  logic                   prev_id_stall_q, prev_id_stall_d;
  logic [STALL_BUS_W-1:0] stall_d;
  logic                   load_use;

  pipe_stall_ctrl_hazard_detect u_hazard_detect (
    .ex_is_load (ex_is_load),
    .ex_waddr   (ex_waddr),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .load_use   (load_use)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    stall_d   = STALL_NONE;
    case (state_q)
      RUN: begin
        if (ex_mc_req) begin
          stall_d = STALL_EX;
          state_d = EX_WAIT;
          cnt_d   = CNT_W'(1);
        end else if (load_use) begin
          stall_d = STALL_LOAD;
          state_d = LD_BUBBLE;
        end
      end
      LD_BUBBLE: begin
        state_d = RUN;
      end
      EX_WAIT: begin
        // a done arriving on the watchdog cycle still counts as a clean finish
        if (ex_mc_done) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(EX_WAIT_MAX)) begin
          timeout_d = 1'b1;
          state_d   = RUN;
          cnt_d     = '0;
        end else begin
          stall_d = STALL_EX;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
    prev_id_stall_d = stall_d[STG_ID];
  end

  assign stall      = STALL_W'(stall_d);
  assign ex_timeout = timeout_q;
  assign id_buf_cap = (stall_d[STG_IF] == STOP) & (stall_d[STG_ID] == STOP) & ~prev_id_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= RUN;
      cnt_q           <= '0;
      timeout_q       <= 1'b0;
      prev_id_stall_q <= NO_STOP;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      timeout_q       <= timeout_d;
      prev_id_stall_q <= prev_id_stall_d;
    end
  end

`ifdef STALL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_load_q, perf_load_d;

  always_comb begin
    perf_stall_d = perf_stall_q + {31'd0, |stall_d};
    perf_load_d  = perf_load_q + {31'd0, (state_q == RUN) && (state_d == LD_BUBBLE)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_load_q  <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_load_q  <= perf_load_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_load_events  = perf_load_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed self-checking bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;

  logic       clk;
  logic       rst;
  logic       ex_is_load;
  logic [4:0] ex_waddr;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       ex_mc_req;
  logic       ex_mc_done;
  logic [5:0] stall;
  logic       id_buf_cap;
  logic       ex_timeout;
`ifdef STALL_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_load_events;
`endif

  int n_assert;
  int n_fail;

  pipe_stall_ctrl #(
    .STALL_W     (6),
    .EX_WAIT_MAX (64),
    .CNT_W       (7)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .ex_is_load        (ex_is_load),
    .ex_waddr          (ex_waddr),
    .id_rs             (id_rs),
    .id_rt             (id_rt),
    .id_use_rs         (id_use_rs),
    .id_use_rt         (id_use_rt),
    .ex_mc_req         (ex_mc_req),
    .ex_mc_done        (ex_mc_done),
    .stall             (stall),
    .id_buf_cap        (id_buf_cap),
`ifdef STALL_PERF_EN
    .perf_stall_cycles (perf_stall_cycles),
    .perf_load_events  (perf_load_events),
`endif
    .ex_timeout        (ex_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_is_load = 1'b0;
    ex_waddr   = 5'd0;
    id_rs      = 5'd0;
    id_rt      = 5'd0;
    id_use_rs  = 1'b0;
    id_use_rt  = 1'b0;
    ex_mc_req  = 1'b0;
    ex_mc_done = 1'b0;
  endtask

  task automatic set_load_rs8();
    ex_is_load = 1'b1;
    ex_waddr   = 5'd8;
    id_rs      = 5'd8;
    id_use_rs  = 1'b1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      #1;
      chk("reset_stall", 32'(stall), 32'h00);
      chk("reset_cap", 32'(id_buf_cap), 32'd0);
      chk("reset_timeout", 32'(ex_timeout), 32'd0);
      next_cycle();
    end

    set_load_rs8();
    #1;
    chk("load_rs_stall", 32'(stall), 32'h07);
    chk("load_rs_cap", 32'(id_buf_cap), 32'd1);
    next_cycle();
    #1;
    chk("bubble_held_stall", 32'(stall), 32'h00);
    chk("bubble_held_cap", 32'(id_buf_cap), 32'd0);
    next_cycle();
    #1;
    chk("reload_held_stall", 32'(stall), 32'h07);
    chk("reload_held_cap", 32'(id_buf_cap), 32'd1);
    next_cycle();
    id_use_rs = 1'b0;
    id_rs     = 5'd3;
    id_rt     = 5'd8;
    id_use_rt = 1'b1;
    #1;
    chk("bubble_ignores_lu", 32'(stall), 32'h00);
    next_cycle();
    #1;
    chk("load_rt_stall", 32'(stall), 32'h07);
    chk("load_rt_cap", 32'(id_buf_cap), 32'd1);
    next_cycle();
    ex_waddr  = 5'd0;
    id_rs     = 5'd0;
    id_rt     = 5'd0;
    id_use_rs = 1'b1;
    id_use_rt = 1'b1;
    #1;
    chk("bubble2_stall", 32'(stall), 32'h00);
    next_cycle();
    #1;
    chk("waddr_zero_stall", 32'(stall), 32'h00);
    ex_waddr  = 5'd8;
    id_rs     = 5'd3;
    id_rt     = 5'd8;
    id_use_rs = 1'b1;
    id_use_rt = 1'b0;
    #1;
    chk("use_flag_off_stall", 32'(stall), 32'h00);
    ex_is_load = 1'b0;
    id_use_rt  = 1'b1;
    #1;
    chk("not_load_stall", 32'(stall), 32'h00);
`ifdef STALL_PERF_EN
    chk("perf_load_events", perf_load_events, 32'd3);
    chk("perf_stall_cycles", perf_stall_cycles, 32'd3);
`endif
    next_cycle();

    idle();
    set_load_rs8();
    #1;
    chk("ldb_entry_stall", 32'(stall), 32'h07);
    next_cycle();
    idle();
    ex_mc_req = 1'b1;
    #1;
    chk("ldb_req_ignored", 32'(stall), 32'h00);
    next_cycle();
    ex_mc_req = 1'b0;
    #1;
    chk("ldb_back_to_run", 32'(stall), 32'h00);

    ex_mc_done = 1'b1;
    #1;
    chk("run_done_ignored", 32'(stall), 32'h00);
    next_cycle();
    ex_mc_done = 1'b0;
    #1;
    chk("run_after_done", 32'(stall), 32'h00);

    ex_mc_req = 1'b1;
    #1;
    chk("mc_entry_stall", 32'(stall), 32'h0f);
    chk("mc_entry_cap", 32'(id_buf_cap), 32'd1);
    next_cycle();
    ex_mc_req = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      #1;
      chk("mc_wait_stall", 32'(stall), 32'h0f);
      chk("mc_wait_cap", 32'(id_buf_cap), 32'd0);
      next_cycle();
    end
    ex_mc_done = 1'b1;
    #1;
    chk("mc_done_stall", 32'(stall), 32'h00);
    next_cycle();
    ex_mc_done = 1'b0;
    #1;
    chk("mc_run_stall", 32'(stall), 32'h00);
    chk("mc_run_timeout", 32'(ex_timeout), 32'd0);

    set_load_rs8();
    ex_mc_req = 1'b1;
    #1;
    chk("prio_stall", 32'(stall), 32'h0f);
    next_cycle();
    idle();
    #1;
    chk("prio_in_exwait", 32'(stall), 32'h0f);
    ex_mc_done = 1'b1;
    #1;
    chk("prio_done_stall", 32'(stall), 32'h00);
    next_cycle();
    idle();

    ex_mc_req = 1'b1;
    #1;
    chk("lim_entry_stall", 32'(stall), 32'h0f);
    next_cycle();
    ex_mc_req = 1'b0;
    for (int i = 1; i <= 63; i++) begin
      #1;
      chk("lim_wait_stall", 32'(stall), 32'h0f);
      next_cycle();
    end
    ex_mc_done = 1'b1;
    #1;
    chk("done_at_max_stall", 32'(stall), 32'h00);
    next_cycle();
    ex_mc_done = 1'b0;
    #1;
    chk("done_wins_timeout", 32'(ex_timeout), 32'd0);
    chk("done_wins_stall", 32'(stall), 32'h00);

    ex_mc_req = 1'b1;
    #1;
    chk("wd_entry_stall", 32'(stall), 32'h0f);
    next_cycle();
    ex_mc_req = 1'b0;
    for (int i = 1; i <= 63; i++) begin
      #1;
      chk("wd_hold_stall", 32'(stall), 32'h0f);
      chk("wd_hold_timeout", 32'(ex_timeout), 32'd0);
      next_cycle();
    end
    #1;
    chk("wd_expire_stall", 32'(stall), 32'h00);
    chk("wd_expire_timeout", 32'(ex_timeout), 32'd0);
    next_cycle();
    #1;
    chk("wd_flag", 32'(ex_timeout), 32'd1);
    chk("wd_run_stall", 32'(stall), 32'h00);
    repeat (3) next_cycle();
    #1;
    chk("wd_sticky", 32'(ex_timeout), 32'd1);

    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    chk("rst_clears_timeout", 32'(ex_timeout), 32'd0);
`ifdef STALL_PERF_EN
    chk("rst_perf_stall", perf_stall_cycles, 32'd0);
    chk("rst_perf_load", perf_load_events, 32'd0);
`endif
    next_cycle();

    ex_mc_req = 1'b1;
    #1;
    chk("mid_entry_stall", 32'(stall), 32'h0f);
    next_cycle();
    ex_mc_req = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      #1;
      chk("mid_wait_stall", 32'(stall), 32'h0f);
      next_cycle();
    end
    #1;
    chk("mid_before_rst", 32'(stall), 32'h0f);
`ifdef STALL_PERF_EN
    chk("mid_perf_stall6", perf_stall_cycles, 32'd6);
`endif
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    chk("mid_rst_run_stall", 32'(stall), 32'h00);
    chk("mid_rst_cap", 32'(id_buf_cap), 32'd0);
`ifdef STALL_PERF_EN
    chk("mid_rst_perf_stall", perf_stall_cycles, 32'd0);
    chk("mid_rst_perf_load", perf_load_events, 32'd0);
`endif
    next_cycle();
    ex_mc_req = 1'b1;
    #1;
    chk("post_rst_entry_stall", 32'(stall), 32'h0f);
    chk("post_rst_entry_cap", 32'(id_buf_cap), 32'd1);
    next_cycle();
    ex_mc_req  = 1'b0;
    ex_mc_done = 1'b1;
    #1;
    chk("post_rst_done_stall", 32'(stall), 32'h00);
    next_cycle();
    idle();
    #1;
    chk("final_stall", 32'(stall), 32'h00);
    chk("final_timeout", 32'(ex_timeout), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
